uart_receiver_fifo: RTL and testbench
=====================================

UART_RECEIVER_FIFO -- requirements
Module: uart_receiver_fifo

Interface
REQ-001 The block SHALL have parameter clk_freq_hz, default 25000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter baud_rate, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have parameter fifo_depth, default 4, meaning receive buffer entries (power of two, 2..16).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port i_rxd, input, 1 bit: asynchronous UART line (ftdi_rxd), idle high.
REQ-007 The block SHALL have port o_data, output, 8 bits: head-of-FIFO byte.
REQ-008 The block SHALL have port o_valid, output, 1 bit: FIFO non-empty.
REQ-009 The block SHALL have port i_ready, input, 1 bit: consumer pop request.
REQ-010 The block SHALL have port o_overrun, output, 1 bit: sticky flag, byte dropped because FIFO full.
REQ-011 The block SHALL have port o_frame_err, output, 1 bit: sticky flag, stop bit sampled low.
REQ-012 The block SHALL have port i_clear_err, input, 1 bit: clears both sticky flags.

Function
REQ-013 i_rxd SHALL pass through a 2-flop synchronizer; all receive logic SHALL use only the synchronized signal rxs.
REQ-014 DIV SHALL equal clk_freq_hz/baud_rate (integer division: 217 at defaults); HALF SHALL equal DIV/2 (108).
REQ-015 The receive FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 In IDLE, rxs=0 SHALL load the counter and enter START.
REQ-017 In START, after HALF cycles the FSM SHALL re-sample rxs: 0 enters DATA; 1 (glitch) returns to IDLE with nothing pushed.
REQ-018 In DATA, the FSM SHALL sample rxs every DIV cycles, 8 times, shifting LSB-first into an 8-bit shift register, then enter STOP.
REQ-019 In STOP, after DIV cycles the FSM SHALL sample rxs and return to IDLE on that same cycle (back-to-back frames supported).
- rxs=1: push the byte.
- rxs=0: discard the byte and set o_frame_err.
REQ-020 A pushed byte SHALL appear with o_valid=1 on the cycle after the stop sample.
REQ-021 The FIFO SHALL be first-word-fall-through: o_data SHALL be the oldest entry whenever o_valid=1, and SHALL be 8'h00 when empty.
REQ-022 A pop SHALL occur on any cycle with o_valid & i_ready; i_ready while empty SHALL be ignored.
REQ-023 A push while full with no pop SHALL drop the new byte, set o_overrun, and leave FIFO contents intact.
REQ-024 Simultaneous push and pop while full SHALL succeed with no overrun; simultaneous push and pop while empty SHALL leave the byte stored, with o_valid=1 on the next cycle.
REQ-025 Pointers SHALL be log2(fifo_depth)+1 bits and wrap modulo 2*fifo_depth; full is MSBs differ and the rest equal; empty is the pointers equal.
REQ-026 i_clear_err SHALL clear both flags on the next edge; if a flag's set event occurs on the same cycle, set SHALL win.

Reset
REQ-027 On i_rst, the FSM SHALL go to IDLE, counters and shift register to 0, synchronizer flops to 1, FIFO pointers to 0, o_valid=0, o_data=8'h00, o_overrun=0, and o_frame_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push and no flag; after release, reception SHALL resume at the next falling edge.

Structure
REQ-029 FSM state encodings and the DIV/HALF computation SHALL live in a shared include uart_defs.vh, reusable by the transmit side.
REQ-030 FIFO storage and pointers SHALL be a sub-module rx_fifo (ports: clk, rst, push, wdata, pop, rdata, empty, full); the FSM and synchronizer SHALL stay in the top module.

Verification
The bench SHALL use clk_freq_hz=1600 and baud_rate=100 (DIV=16, HALF=8).
REQ-031 Frame 0x55 with a good stop bit -> o_valid rises exactly 1 cycle after the stop sample; o_data=0x55; no flags.
REQ-032 5 back-to-back frames 0x01..0x05 with i_ready=0 -> 4 stored, o_overrun=1; popping returns 0x01,0x02,0x03,0x04, then o_valid=0.
REQ-033 Frame 0xA3 with stop bit low -> o_frame_err=1, o_valid stays 0; pulse i_clear_err -> flag reads 0 on the next cycle.
REQ-034 Low glitch of 3 cycles on i_rxd -> FSM returns to IDLE, no push, no flags.
REQ-035 FIFO full with i_ready held 1 at the cycle a 5th byte 0x77 pushes -> no overrun; 0x77 is the last of the 4 remaining entries.
REQ-036 i_rst asserted during the 4th data bit of 0xFF, then frame 0x3C -> only 0x3C is received; all outputs read reset values during reset.

Source files
------------

// File: rtl/uart_receiver_fifo_pkg.sv
// Shared UART definitions: receive FSM state encoding and bit-timing helpers.
// Also meant for reuse by a UART transmitter.
package uart_receiver_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  // Clocks per bit (integer division).
  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Clocks from start-edge detection to mid start bit.
  function automatic int uart_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver.
// Ports: clk, rst (sync, active-high), push/wdata, pop, rdata (0 when empty), empty, full.
module rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [7:0]  mem_q [DEPTH];
  logic        we;
  logic        re;

  always_comb begin
    empty = (wr_q == rd_q);
    full  = (wr_q[AW] != rd_q[AW]) &&
            (wr_q[AW-1:0] == rd_q[AW-1:0]);
    re    = pop & ~empty;
    // A pop on the same cycle frees a slot, so a full FIFO still accepts.
    we    = push & (~full | re);
    wr_d  = we ? wr_q + 1'b1 : wr_q;
    rd_d  = re ? rd_q + 1'b1 : rd_q;
    rdata = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/uart_receiver_fifo.sv
// 8N1 UART receiver with a FWFT receive FIFO and sticky overrun/framing flags.
// Ports: i_clk, i_rst (sync, active-high), i_rxd (async line), o_data/o_valid/i_ready
// (FIFO head and pop), o_overrun, o_frame_err, i_clear_err.
module uart_receiver_fifo
  import uart_receiver_fifo_pkg::*;
#(
  parameter int clk_freq_hz = 25000000,
  parameter int baud_rate   = 115200,
  parameter int fifo_depth  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_overrun,
  output logic       o_frame_err,
  input  logic       i_clear_err
);

  localparam int DIV  = uart_div(clk_freq_hz, baud_rate);
  localparam int HALF = uart_half(DIV);
  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic [1:0]    sync_q, sync_d;
  logic          rxs;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  logic          push;
  logic          ferr_set;
  logic          pop;
  logic          empty;
  logic          full;
  logic [7:0]    rdata;

  assign rxs = sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], i_rxd};
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cnt_d   = HALF_M1;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          // High at mid start bit means a glitch.
          if (!rxs) begin
            state_d = ST_DATA;
            cnt_d   = DIV_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = DIV_M1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          // Back to idle at mid stop bit so the next start edge is seen.
          state_d  = ST_IDLE;
          push     = rxs;
          ferr_set = ~rxs;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop    = ~empty & i_ready;
    // Set wins over clear.
    ovr_d  = (push & full & ~pop) | (ovr_q & ~i_clear_err);
    ferr_d = ferr_set | (ferr_q & ~i_clear_err);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  rx_fifo #(
    .DEPTH(fifo_depth)
  ) u_fifo (
    .clk  (i_clk),
    .rst  (i_rst),
    .push (push),
    .wdata(shift_q),
    .pop  (pop),
    .rdata(rdata),
    .empty(empty),
    .full (full)
  );

  assign o_data      = rdata;
  assign o_valid     = ~empty;
  assign o_overrun   = ovr_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Directed bench for uart_receiver_fifo at DIV=16, HALF=8.
// Frames are driven on negedges, outputs sampled on negedges.
module tb_uart_receiver_fifo;
  import uart_receiver_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_overrun;
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;
  logic [7:0] snap_data;
  logic snap_valid, snap_ovr, snap_ferr;

  uart_receiver_fifo #(
    .clk_freq_hz(1600),
    .baud_rate  (100),
    .fifo_depth (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rxd      (rxd),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_overrun  (o_overrun),
    .o_frame_err(o_frame_err),
    .i_clear_err(clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = o_valid;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 10-bit frame, 16 clocks per bit. pop_at / rst window are
  // negedge indices within the frame (-1 = unused).
  task automatic send(input logic [7:0] d, input logic stop,
                      input int pop_at, input int rst_from,
                      input int rst_to);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    start_cyc = cyc;
    for (int n = 0; n < 160; n++) begin
      if (n == 71) begin
        snap_data  = o_data;
        snap_valid = o_valid;
        snap_ovr   = o_overrun;
        snap_ferr  = o_frame_err;
      end
      if (n % 16 == 0) rxd = fr[n/16];
      rdy = (n == pop_at);
      rst = (n >= rst_from) && (n < rst_to);
      @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic pop1();
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic clear_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_q [4];

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 32'h00);
    check("rst_ovr", 32'(o_overrun), 0);
    check("rst_ferr", 32'(o_frame_err), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 0x55, good stop: valid one cycle after stop sample (edge 155).
    rise_cyc = -1;
    send(8'h55, 1'b1, -1, -1, -1);
    check("t1_rise", 32'(rise_cyc), 32'(start_cyc + 155));
    check("t1_data", 32'(o_data), 32'h55);
    check("t1_ovr", 32'(o_overrun), 0);
    check("t1_ferr", 32'(o_frame_err), 0);
    pop1();
    check("t1_empty", 32'(o_valid), 0);

    // Five back-to-back frames, no pops: overrun, first four kept.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1, -1, -1);
    repeat (4) @(negedge clk);
    check("t2_ovr", 32'(o_overrun), 1);
    for (int i = 1; i <= 4; i++) begin
      check("t2_valid", 32'(o_valid), 1);
      check("t2_data", 32'(o_data), 32'(i));
      pop1();
    end
    check("t2_empty", 32'(o_valid), 0);
    check("t2_empty_data", 32'(o_data), 0);
    clear_pulse();
    check("t2_ovr_clr", 32'(o_overrun), 0);

    // 0xA3 with low stop bit: framing error, nothing stored.
    send(8'hA3, 1'b0, -1, -1, -1);
    repeat (4) @(negedge clk);
    check("t3_ferr", 32'(o_frame_err), 1);
    check("t3_valid", 32'(o_valid), 0);
    clear_pulse();
    check("t3_ferr_clr", 32'(o_frame_err), 0);

    // 3-cycle low glitch.
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("t4_valid", 32'(o_valid), 0);
    check("t4_ovr", 32'(o_overrun), 0);
    check("t4_ferr", 32'(o_frame_err), 0);

    // Full FIFO, pop on the same edge as the push of 0x77.
    send(8'h10, 1'b1, -1, -1, -1);
    send(8'h20, 1'b1, -1, -1, -1);
    send(8'h30, 1'b1, -1, -1, -1);
    send(8'h40, 1'b1, -1, -1, -1);
    check("t5_head", 32'(o_data), 32'h10);
    send(8'h77, 1'b1, 154, -1, -1);
    repeat (2) @(negedge clk);
    check("t5_ovr", 32'(o_overrun), 0);
    exp_q = '{8'h20, 8'h30, 8'h40, 8'h77};
    for (int i = 0; i < 4; i++) begin
      check("t5_valid", 32'(o_valid), 1);
      check("t5_data", 32'(o_data), 32'(exp_q[i]));
      pop1();
    end
    check("t5_empty", 32'(o_valid), 0);

    // Leave a byte and a flag, then reset during data bit 3 of 0xFF.
    send(8'h5A, 1'b1, -1, -1, -1);
    send(8'hA3, 1'b0, -1, -1, -1);
    check("t6_pre_valid", 32'(o_valid), 1);
    check("t6_pre_ferr", 32'(o_frame_err), 1);
    send(8'hFF, 1'b1, -1, 68, 73);
    check("t6_rst_valid", 32'(snap_valid), 0);
    check("t6_rst_data", 32'(snap_data), 0);
    check("t6_rst_ovr", 32'(snap_ovr), 0);
    check("t6_rst_ferr", 32'(snap_ferr), 0);
    check("t6_abort", 32'(o_valid), 0);
    send(8'h3C, 1'b1, -1, -1, -1);
    repeat (2) @(negedge clk);
    check("t6_valid", 32'(o_valid), 1);
    check("t6_data", 32'(o_data), 32'h3C);
    check("t6_ferr", 32'(o_frame_err), 0);
    check("t6_ovr", 32'(o_overrun), 0);
    pop1();
    check("t6_empty", 32'(o_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
